// File: rtl/i2s_recv_if.sv
// I2S receiver pin/bus bundle: serial pins in, deframed stereo words out.
interface i2s_recv_if #(
  parameter int unsigned SIZE = 8
) ();
  logic            sck;
  logic            ws;
  logic            sd;
  logic [SIZE-1:0] data_left;
  logic [SIZE-1:0] data_right;
  logic            valid;
  logic            locked;
  logic            len_err;

  // Serial source side: drives the pins, observes the parallel result.
  modport master (
    output sck, ws, sd,
    input  data_left, data_right, valid, locked, len_err
  );

  // Receiver side: samples the pins, presents the parallel result.
  modport slave (
    input  sck, ws, sd,
    output data_left, data_right, valid, locked, len_err
  );
endinterface

// File: rtl/i2s_recv.sv
// I2S receiver: synchronizes sck/ws/sd into Clk, deframes MSB-first left/right
// words and presents each completed stereo frame with a one-cycle valid.
// Optional word-length checking is enabled by defining I2S_RECV_LEN_CHECK_EN.
module i2s_recv #(
  parameter int unsigned SIZE = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  i2s_recv_if.slave  bus
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic            r_sck_s1, r_sck_s2, r_sck_q;
  logic            r_ws_s1, r_ws_s2;
  logic            r_sd_s1, r_sd_s2;

  logic [0:0]      r_state;
  logic            r_ws_prev;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_sh;
  logic [SIZE-1:0] r_hold_left;
  logic [SIZE-1:0] r_data_left;
  logic [SIZE-1:0] r_data_right;
  logic            r_valid;

  logic            w_strobe;
  logic            w_trans;
  logic            w_room;
  logic [SIZE-1:0] w_sh_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_len_err;

  assign w_strobe = r_sck_s2 & ~r_sck_q;
  assign w_trans  = r_ws_s2 ^ r_ws_prev;
  assign w_room   = (r_cnt < CW'(SIZE));

  // Two-flop synchronizers on all pins, plus an edge-detect flop on sck.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_q  <= 1'b0;
      r_ws_s1  <= 1'b0;
      r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0;
      r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= bus.sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_q  <= r_sck_s2;
      r_ws_s1  <= bus.ws;
      r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= bus.sd;
      r_sd_s2  <= r_sd_s1;
    end
  end

  // Word with the current bit placed at position SIZE-1-cnt; extra bits dropped.
  always_comb begin
    w_sh_next  = r_sh;
    w_cnt_next = r_cnt;
    if (w_room) begin
      w_cnt_next = r_cnt + CW'(1);
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (CW'(SIZE - 1 - i) == r_cnt) begin
          w_sh_next[i] = r_sd_s2;
        end
      end
    end
  end

  // Deframing: accumulate bits, close a word on each ws transition.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_UNLOCKED;
      r_ws_prev    <= 1'b0;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_hold_left  <= '0;
      r_data_left  <= '0;
      r_data_right <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_strobe) begin
        if (w_trans) begin
          r_sh      <= '0;
          r_cnt     <= '0;
          r_ws_prev <= r_ws_s2;
          if (!r_ws_prev) begin
            r_hold_left <= w_sh_next;
          end else if (r_state == ST_LOCKED) begin
            r_data_left  <= r_hold_left;
            r_data_right <= w_sh_next;
            r_valid      <= 1'b1;
          end else begin
            r_state <= ST_LOCKED;
          end
        end else begin
          r_sh  <= w_sh_next;
          r_cnt <= w_cnt_next;
        end
      end
    end
  end

`ifdef I2S_RECV_LEN_CHECK_EN
  logic r_ovf;
  logic r_left_bad;
  logic r_len_err;
  logic w_word_bad;

  // A word is good only if its last bit lands exactly in the LSB slot and no
  // bit was ever dropped; r_ovf remembers drops since cnt saturates at SIZE.
  assign w_word_bad = r_ovf | (r_cnt != CW'(SIZE - 1));

  // Track per-word length errors and publish them alongside valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ovf      <= 1'b0;
      r_left_bad <= 1'b0;
      r_len_err  <= 1'b0;
    end else if (w_strobe) begin
      if (w_trans) begin
        r_ovf <= 1'b0;
        if (!r_ws_prev) begin
          r_left_bad <= w_word_bad;
        end else if (r_state == ST_LOCKED) begin
          r_len_err <= r_left_bad | w_word_bad;
        end
      end else if (!w_room) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_len_err = r_len_err;
`else
  assign w_len_err = 1'b0;
`endif

  assign bus.data_left  = r_data_left;
  assign bus.data_right = r_data_right;
  assign bus.valid      = r_valid;
  assign bus.locked     = (r_state == ST_LOCKED);
  assign bus.len_err    = w_len_err;

endmodule

// File: tb/tb_i2s_recv.sv
// Scoreboard bench for i2s_recv (SIZE=8, sck = Clk/8): directed I2S streams
// push expected frames; a monitor pops and compares on every valid pulse.
module tb_i2s_recv;

  localparam int unsigned SIZE = 8;
`ifdef I2S_RECV_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic Clk;
  logic Reset;

  i2s_recv_if #(.SIZE(SIZE)) bus ();

  i2s_recv #(.SIZE(SIZE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int frames_expected = 0;

  logic [7:0] exp_l[$];
  logic [7:0] exp_r[$];
  logic       exp_e[$];

  logic bit_sd[$];
  logic bit_ch[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] l, input logic [7:0] r, input logic bad);
    exp_l.push_back(l);
    exp_r.push_back(r);
    exp_e.push_back(bad & LEN_EN);
    frames_expected++;
  endtask

  task automatic add_slot(input logic ch, input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_sd.push_back(w[i]);
      bit_ch.push_back(ch);
    end
  endtask

  // ws leads data by one bit: the LSB of a word is sent with the next ws value.
  // After the last bit ws is left at 0 so the final word closes cleanly.
  task automatic play();
    int n;
    n = bit_sd.size();
    for (int j = 0; j < n; j++) begin
      @(posedge Clk); #1;
      bus.sck = 1'b0;
      bus.sd  = bit_sd[j];
      bus.ws  = (j + 1 < n) ? bit_ch[j + 1] : 1'b0;
      repeat (4) @(posedge Clk);
      #1 bus.sck = 1'b1;
      repeat (3) @(posedge Clk);
    end
    @(posedge Clk); #1 bus.sck = 1'b0;
    bit_sd.delete();
    bit_ch.delete();
    repeat (16) @(posedge Clk);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clk); #1;
    bus.sck = 1'b0;
    Reset   = 1'b1;
    repeat (cycles) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] l, input logic [7:0] r,
                             input logic lk, input logic le);
    chk({tag, "_data_left"},  {8'h00, bus.data_left},  {8'h00, l});
    chk({tag, "_data_right"}, {8'h00, bus.data_right}, {8'h00, r});
    chk({tag, "_valid"},      {15'd0, bus.valid},      16'd0);
    chk({tag, "_locked"},     {15'd0, bus.locked},     {15'd0, lk});
    chk({tag, "_len_err"},    {15'd0, bus.len_err},    {15'd0, le});
  endtask

  // Monitor: compare every valid against the scoreboard, and check pulse width.
  initial begin
    logic prev_v;
    logic [7:0] el, er;
    logic ee;
    prev_v = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.valid === 1'b1) begin
        valid_seen++;
        chk("valid_width", {15'd0, prev_v}, 16'd0);
        if (exp_l.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got L=%h R=%h expected no frame",
                   bus.data_left, bus.data_right);
        end else begin
          el = exp_l.pop_front();
          er = exp_r.pop_front();
          ee = exp_e.pop_front();
          chk("frame_left",    {8'h00, bus.data_left},  {8'h00, el});
          chk("frame_right",   {8'h00, bus.data_right}, {8'h00, er});
          chk("frame_len_err", {15'd0, bus.len_err},    {15'd0, ee});
        end
      end
      prev_v = bus.valid;
    end
  end

  initial begin
    Reset   = 1'b1;
    bus.sck = 1'b0;
    bus.ws  = 1'b0;
    bus.sd  = 1'b0;

    // 1: reset with idle pins
    do_reset(4);
    chk_outputs("reset", 8'h00, 8'h00, 1'b0, 1'b0);

    // 2: garbage right slot, then A5/3C; lock on first 1->0 ws edge
    expect_frame(8'hA5, 8'h3C, 1'b0);
    add_slot(1'b1, 16'h00FF, 8);
    add_slot(1'b0, 16'h00A5, 8);
    add_slot(1'b1, 16'h003C, 8);
    play();
    chk("t2_locked", {15'd0, bus.locked}, 16'd1);
    repeat (40) @(posedge Clk);
    #1 chk_outputs("t2_hold", 8'hA5, 8'h3C, 1'b1, 1'b0);

    // 3: long 16-bit slots are truncated to the top 8 bits
    expect_frame(8'hA5, 8'h0F, 1'b1);
    add_slot(1'b0, 16'hA5F0, 16);
    add_slot(1'b1, 16'h0F0F, 16);
    play();

    // 4: short 6-bit slots are zero-padded in the LSBs
    expect_frame(8'hB4, 8'h0C, 1'b1);
    add_slot(1'b0, 16'h002D, 6);
    add_slot(1'b1, 16'h0003, 6);
    play();
    chk("t4_hold_len_err", {15'd0, bus.len_err}, {15'd0, LEN_EN});

    // 6: back-to-back frames, no stale mixing
    expect_frame(8'h01, 8'h02, 1'b0);
    expect_frame(8'h03, 8'h04, 1'b0);
    add_slot(1'b0, 16'h0001, 8);
    add_slot(1'b1, 16'h0002, 8);
    add_slot(1'b0, 16'h0003, 8);
    add_slot(1'b1, 16'h0004, 8);
    play();
    #1 chk_outputs("t6_hold", 8'h03, 8'h04, 1'b1, 1'b0);

    // 5: reset mid-left-word; resync needs a fresh 1->0 edge then a full frame
    add_slot(1'b0, 16'h000F, 4);
    bit_ch.push_back(1'b0);
    bit_sd.push_back(1'b1);
    play();
    do_reset(3);
    chk_outputs("t5_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    add_slot(1'b0, 16'h0011, 8);
    add_slot(1'b1, 16'h0022, 8);
    play();
    chk("t5_relock", {15'd0, bus.locked}, 16'd1);
    expect_frame(8'h33, 8'h44, 1'b0);
    add_slot(1'b0, 16'h0033, 8);
    add_slot(1'b1, 16'h0044, 8);
    play();

    repeat (40) @(posedge Clk);
    #1;
    chk("pending_frames", 16'(exp_l.size()), 16'd0);
    chk("valid_count", 16'(valid_seen), 16'(frames_expected));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
